// File: rtl/lab3_arbiter_4req.sv
// Four-requester arbiter: fixed-priority or round-robin winner selection,
// grant held until done, grantee drop, or MAX_HOLD expiry.
// Ports:
//   clk       - system clock, rising edge
//   rst_n     - synchronous active-low reset
//   req[3:0]  - level request vector, bit i = requester i
//   done      - release strobe from the current grantee
//   rr_mode   - 0 = fixed priority (req0 highest), 1 = round-robin
//   gnt[3:0]  - registered one-hot grant
//   gnt_id    - registered binary index of the grantee
//   gnt_valid - registered, high while a grant is active
//   timeout   - one-cycle pulse when MAX_HOLD revokes a grant
module lab3_arbiter_4req #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    input  logic       rr_mode,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    localparam logic [HOLD_W-1:0] L_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] L_SAT = '1;
    localparam logic [HOLD_W-1:0] L_ONE = HOLD_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_gnt;
    logic [3:0]        w_gnt_nxt;
    logic [1:0]        r_gnt_id;
    logic [1:0]        w_id_nxt;
    logic              r_gnt_valid;
    logic              w_valid_nxt;
    logic              r_timeout;
    logic              w_to_nxt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic [1:0]        r_last_id;
    logic [1:0]        w_last_nxt;

    logic [1:0]        w_fix_id;
    logic [1:0]        w_start;
    logic [7:0]        w_dbl;
    logic [3:0]        w_rot;
    logic [1:0]        w_rr_off;
    logic [1:0]        w_winner;
    logic              w_hold_lim;
    logic              w_drop;
    logic              w_release;

    // Lowest set bit wins; all-zero input maps to 0 (caller gates on |v).
    function automatic logic [1:0] f_enc(input logic [3:0] v);
        logic [1:0] id;
        casez (v)
            4'b???1: id = 2'd0;
            4'b??10: id = 2'd1;
            4'b?100: id = 2'd2;
            4'b1000: id = 2'd3;
            default: id = 2'd0;
        endcase
        return id;
    endfunction

    // Round-robin: rotate req so the search start lands at bit 0, encode,
    // then add the start back (2-bit add gives the 3->0 wrap for free).
    assign w_fix_id = f_enc(req);
    assign w_start  = r_last_id + 2'd1;
    assign w_dbl    = {req, req};
    assign w_rot    = w_dbl[w_start +: 4];
    assign w_rr_off = f_enc(w_rot);
    assign w_winner = rr_mode ? (w_start + w_rr_off) : w_fix_id;

    assign w_hold_lim = (MAX_HOLD != 0) && (r_hold_cnt == L_MAX);
    assign w_drop     = ~req[r_gnt_id];
    assign w_release  = done | w_drop | w_hold_lim;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_gnt       <= 4'b0000;
            r_gnt_id    <= 2'b00;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_hold_cnt  <= '0;
            r_last_id   <= 2'b11;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_id    <= w_id_nxt;
            r_gnt_valid <= w_valid_nxt;
            r_timeout   <= w_to_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_last_id   <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_id_nxt    = r_gnt_id;
        w_valid_nxt = r_gnt_valid;
        w_to_nxt    = 1'b0;
        w_hold_nxt  = r_hold_cnt;
        w_last_nxt  = r_last_id;
        unique case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_nxt = S_BUSY;
                    w_gnt_nxt   = 4'b0001 << w_winner;
                    w_id_nxt    = w_winner;
                    w_valid_nxt = 1'b1;
                    w_hold_nxt  = L_ONE;
                    w_last_nxt  = w_winner;
                end else begin
                    w_gnt_nxt   = 4'b0000;
                    w_valid_nxt = 1'b0;
                    w_hold_nxt  = '0;
                end
            end
            S_BUSY: begin
                if (w_release) begin
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = 4'b0000;
                    w_valid_nxt = 1'b0;
                    w_hold_nxt  = '0;
                    // Only a pure expiry counts as a timeout.
                    w_to_nxt    = w_hold_lim & ~done & ~w_drop;
                end else if (r_hold_cnt != L_SAT) begin
                    w_hold_nxt = r_hold_cnt + L_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;

endmodule

// File: doc/lab3_arbiter_4req.md
Name: lab3_arbiter_4req

Overview:
Four-requester arbiter that shares one downstream resource between requesters 0..3. Each grant lasts until the grantee releases the resource or a hold-time limit expires. Winner selection follows the team's 4-bit priority-encoder convention: lowest index wins, and the 2-bit index plus a valid flag are reported alongside a one-hot grant. A mode input selects fixed priority or round-robin rotation.

Parameters:
MAX_HOLD, 8, maximum consecutive cycles gnt may stay asserted for one grant; 0 = unlimited
HOLD_W, 4, width of internal hold counter; MAX_HOLD must be < 2^HOLD_W

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
req  input  4  request vector, bit i = requester i; level-sensitive, not latched
done  input  1  release strobe from current grantee; ignored in IDLE
rr_mode  input  1  0 = fixed priority (index 0 highest), 1 = round-robin
gnt  output  4  one-hot grant, all-zero when idle
gnt_id  output  2  binary index of grantee (encoder format: req0->00 ... req3->11)
gnt_valid  output  1  high while a grant is active (equals |gnt)
timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry

Behaviour:
- One clock: clk. Reset is synchronous and active-low: rst_n low at a rising edge clears all state.
- Reset values: state=IDLE, gnt=0000, gnt_id=00, gnt_valid=0, timeout=0, hold_cnt=0, last_id=11. With last_id=11, round-robin's first search starts at index 0.
- All outputs are registered.
- Two states: IDLE and BUSY.
- IDLE:
  - If req != 0, compute the winner from req and rr_mode in that cycle.
  - At the next edge: state=BUSY, gnt=onehot(winner), gnt_id=winner, gnt_valid=1, hold_cnt=1, last_id=winner.
  - If req == 0, stay in IDLE with outputs 0.
  - Grant latency is 1 cycle from req sampled in IDLE.
- Fixed mode: the lowest set index wins (req=0110 -> 01).
- Round-robin mode:
  - Search starts at (last_id+1) mod 4 and proceeds upward with wrap 3->0.
  - The first set bit wins.
  - last_id updates only on grant.
- rr_mode is sampled only in IDLE; changes during BUSY have no effect on the current grant.
- BUSY release conditions, evaluated every cycle:
  - (a) done=1
  - (b) req[gnt_id]=0
  - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD
- Any release condition true: at the next edge state=IDLE, gnt=0000, gnt_valid=0, gnt_id holds its last value, hold_cnt=0.
- timeout=1 for that single edge only when (c) is true and neither (a) nor (b) is true. When done and expiry coincide, the release is not a timeout.
- No release condition true: hold_cnt increments, saturating at 2^HOLD_W-1 when MAX_HOLD=0.
- gnt is therefore high for at most MAX_HOLD consecutive cycles.
- Mandatory gap: after every release, exactly one cycle with gnt=0000 (the IDLE arbitration cycle) precedes the next grant, even with requests pending.
- Non-granted requesters may raise or drop req freely during BUSY with no effect. A pulse that rises and falls entirely within BUSY is lost.
- The same requester may be re-granted immediately after release in fixed mode if it is still the lowest requester. In round-robin mode it is re-granted only if no other request is present.
- Reset mid-grant: at the next edge gnt drops and all state returns to reset values; no timeout pulse.

Test Plan:
1. Fixed priority: rr_mode=0, req=0110 in IDLE -> next edge gnt=0010, gnt_id=01, gnt_valid=1; done pulse -> gnt=0000 next edge, then gnt=0010 again after one idle cycle.
2. Round-robin rotation: rr_mode=1, req=1111 held, done pulsed one cycle after each grant -> gnt_id sequence 00,01,10,11,00. Each grant is separated by exactly one cycle of gnt=0000.
3. Timeout: MAX_HOLD=8, req=1000 held, done=0 -> gnt=1000 for exactly 8 cycles; timeout=1 on the edge gnt drops; one idle cycle; regrant gnt=1000.
4. Grantee drop: requester 2 granted, req[2] deasserted -> gnt=0000 next edge, timeout stays 0. Meanwhile a pulse on req[0] fully inside BUSY -> never granted.
5. Coincident release: done=1 in the cycle hold_cnt==MAX_HOLD -> release, timeout=0. Toggling rr_mode during BUSY does not change the current grant.
6. Reset mid-grant: rr_mode=1, gnt=0100, rst_n=0 for one edge -> all outputs 0; after reset, req=1111 -> first grant gnt_id=00.
